// File: rtl/pixel_stream_to_axis.sv
// rtl/pixel_stream_to_axis.sv - pixel stream to AXI4-Stream video bridge
// Two-entry skid FIFO with SOF/EOL tagging, line-length checking and frame counting.
module pixel_stream_to_axis #(
  parameter int Height = 1080,
  parameter int Width  = 1920
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        slave_valid_i,
  output logic        slave_ready_o,
  input  logic [7:0]  slave_red_i,
  input  logic [7:0]  slave_green_i,
  input  logic [7:0]  slave_blue_i,
  input  logic        slave_last_i,
  output logic        master_valid_o,
  input  logic        master_ready_i,
  output logic [23:0] master_data_o,
  output logic        master_user_o,
  output logic        master_last_o,
  output logic        line_error_o,
  output logic [15:0] frame_count_o
);

  localparam int XW = (Width > 1) ? $clog2(Width) : 1;
  localparam int YW = (Height > 1) ? $clog2(Height) : 1;
  localparam logic [XW-1:0] XMax = XW'(Width - 1);
  localparam logic [YW-1:0] YMax = YW'(Height - 1);

  logic [1:0]    count;
  logic [1:0]    count_next;
  logic [25:0]   skid;
  logic [25:0]   pix;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          in_fire;
  logic          out_fire;
  logic          at_eol;
  logic          pix_last;
  logic          pix_user;

  assign in_fire        = slave_valid_i & slave_ready_o;
  assign out_fire       = master_valid_o & master_ready_i;
  assign master_valid_o = (count != 2'd0);
  assign at_eol         = (x == XMax);
  assign pix_last       = at_eol | slave_last_i;
  assign pix_user       = (x == '0) && (y == '0);
  // Entry layout: {user, last, red, blue, green}
  assign pix            = {pix_user, pix_last, slave_red_i, slave_blue_i, slave_green_i};

  always_comb begin
    count_next = count;
    if (in_fire && !out_fire)
      count_next = count + 2'd1;
    else if (!in_fire && out_fire)
      count_next = count - 2'd1;
  end

  // The output registers are the FIFO head; skid holds the second entry.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count         <= 2'd0;
      slave_ready_o <= 1'b0;
      skid          <= '0;
      master_user_o <= 1'b0;
      master_last_o <= 1'b0;
      master_data_o <= '0;
    end else begin
      count         <= count_next;
      slave_ready_o <= (count_next != 2'd2);
      if (out_fire) begin
        if (count == 2'd2)
          {master_user_o, master_last_o, master_data_o} <= skid;
        else if (in_fire)
          {master_user_o, master_last_o, master_data_o} <= pix;
      end else if (in_fire) begin
        if (count == 2'd0)
          {master_user_o, master_last_o, master_data_o} <= pix;
        else
          skid <= pix;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      x             <= '0;
      y             <= '0;
      line_error_o  <= 1'b0;
      frame_count_o <= '0;
    end else if (in_fire) begin
      if (slave_last_i != at_eol)
        line_error_o <= 1'b1;
      if (pix_last) begin
        x <= '0;
        if (y == YMax) begin
          y             <= '0;
          frame_count_o <= frame_count_o + 16'd1;
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_to_axis.sv
// tb/tb_pixel_stream_to_axis.sv - directed self-checking bench for pixel_stream_to_axis
// Height=2, Width=3; output transfers are captured at the falling edge and compared in order.
module tb_pixel_stream_to_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_valid_i = 1'b0;
  logic        slave_ready_o;
  logic [7:0]  slave_red_i = '0;
  logic [7:0]  slave_green_i = '0;
  logic [7:0]  slave_blue_i = '0;
  logic        slave_last_i = 1'b0;
  logic        master_valid_o;
  logic        master_ready_i = 1'b0;
  logic [23:0] master_data_o;
  logic        master_user_o;
  logic        master_last_o;
  logic        line_error_o;
  logic [15:0] frame_count_o;

  int checks = 0;
  int errors = 0;
  logic [25:0] q[$];
  logic [25:0] exp_q[$];

  pixel_stream_to_axis #(.Height(2), .Width(3)) dut (
    .clock_i(clk),
    .reset_i(rst),
    .slave_valid_i(slave_valid_i),
    .slave_ready_o(slave_ready_o),
    .slave_red_i(slave_red_i),
    .slave_green_i(slave_green_i),
    .slave_blue_i(slave_blue_i),
    .slave_last_i(slave_last_i),
    .master_valid_o(master_valid_o),
    .master_ready_i(master_ready_i),
    .master_data_o(master_data_o),
    .master_user_o(master_user_o),
    .master_last_o(master_last_o),
    .line_error_o(line_error_o),
    .frame_count_o(frame_count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && master_valid_o && master_ready_i)
      q.push_back({master_user_o, master_last_o, master_data_o});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] px(input logic u, input logic l,
                                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {u, l, r, b, g};
  endfunction

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic l);
    bit ok;
    ok = 1'b0;
    slave_valid_i = 1'b1;
    slave_red_i   = r;
    slave_green_i = g;
    slave_blue_i  = b;
    slave_last_i  = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (slave_ready_o) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    slave_valid_i = 1'b0;
    slave_last_i  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_q(input string tag);
    check_eq({tag, "_count"}, 32'(q.size()), 32'(exp_q.size()));
    for (int i = 0; i < q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), 32'(q[i]), 32'(exp_q[i]));
    q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(master_valid_o), 32'd0);
    check_eq("rst_ready", 32'(slave_ready_o), 32'd0);
    check_eq("rst_data", 32'(master_data_o), 32'd0);
    check_eq("rst_user", 32'(master_user_o), 32'd0);
    check_eq("rst_last", 32'(master_last_o), 32'd0);
    check_eq("rst_lerr", 32'(line_error_o), 32'd0);
    check_eq("rst_fcnt", 32'(frame_count_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", 32'(slave_ready_o), 32'd1);

    // Streaming: one full frame back to back
    master_ready_i = 1'b1;
    send(8'h01, 8'h41, 8'h81, 1'b0);
    check_eq("lat_valid", 32'(master_valid_o), 32'd1);
    check_eq("lat_data", 32'(master_data_o), 32'h018141);
    check_eq("lat_user", 32'(master_user_o), 32'd1);
    send(8'h02, 8'h42, 8'h82, 1'b0);
    send(8'h03, 8'h43, 8'h83, 1'b1);
    send(8'h04, 8'h44, 8'h84, 1'b0);
    send(8'h05, 8'h45, 8'h85, 1'b0);
    send(8'h06, 8'h46, 8'h86, 1'b1);
    idle(4);
    exp_q.push_back(px(1, 0, 8'h01, 8'h41, 8'h81));
    exp_q.push_back(px(0, 0, 8'h02, 8'h42, 8'h82));
    exp_q.push_back(px(0, 1, 8'h03, 8'h43, 8'h83));
    exp_q.push_back(px(0, 0, 8'h04, 8'h44, 8'h84));
    exp_q.push_back(px(0, 0, 8'h05, 8'h45, 8'h85));
    exp_q.push_back(px(0, 1, 8'h06, 8'h46, 8'h86));
    compare_q("stream");
    check_eq("stream_fcnt", 32'(frame_count_o), 32'd1);
    check_eq("stream_lerr", 32'(line_error_o), 32'd0);

    // Component order
    send(8'h11, 8'h22, 8'h33, 1'b0);
    idle(3);
    check_eq("rgb_order", 32'(master_data_o), 32'h113322);
    exp_q.push_back(px(1, 0, 8'h11, 8'h22, 8'h33));
    compare_q("component");

    // Backpressure: third pixel must wait
    master_ready_i = 1'b0;
    send(8'ha1, 8'ha2, 8'ha3, 1'b0);
    send(8'hb1, 8'hb2, 8'hb3, 1'b1);
    slave_valid_i = 1'b1;
    slave_red_i   = 8'hc1;
    slave_green_i = 8'hc2;
    slave_blue_i  = 8'hc3;
    slave_last_i  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_ready_low", 32'(slave_ready_o), 32'd0);
      check_eq("bp_hold_data", 32'(master_data_o), 32'ha1a3a2);
      check_eq("bp_hold_valid", 32'(master_valid_o), 32'd1);
    end
    @(posedge clk);
    #1;
    master_ready_i = 1'b1;
    send(8'hc1, 8'hc2, 8'hc3, 1'b0);
    idle(4);
    exp_q.push_back(px(0, 0, 8'ha1, 8'ha2, 8'ha3));
    exp_q.push_back(px(0, 1, 8'hb1, 8'hb2, 8'hb3));
    exp_q.push_back(px(0, 0, 8'hc1, 8'hc2, 8'hc3));
    compare_q("backpressure");

    send(8'hd1, 8'hd2, 8'hd3, 1'b0);
    send(8'hd4, 8'hd5, 8'hd6, 1'b1);
    idle(3);
    check_eq("frame2_fcnt", 32'(frame_count_o), 32'd2);
    check_eq("frame2_lerr", 32'(line_error_o), 32'd0);
    q.delete();

    // Early end on pixel 2 of line 0
    send(8'he1, 8'he2, 8'he3, 1'b0);
    send(8'he4, 8'he5, 8'he6, 1'b1);
    check_eq("early_lerr", 32'(line_error_o), 32'd1);
    send(8'he7, 8'he8, 8'he9, 1'b0);
    send(8'hea, 8'heb, 8'hec, 1'b0);
    send(8'hed, 8'hee, 8'hef, 1'b1);
    idle(3);
    exp_q.push_back(px(1, 0, 8'he1, 8'he2, 8'he3));
    exp_q.push_back(px(0, 1, 8'he4, 8'he5, 8'he6));
    exp_q.push_back(px(0, 0, 8'he7, 8'he8, 8'he9));
    exp_q.push_back(px(0, 0, 8'hea, 8'heb, 8'hec));
    exp_q.push_back(px(0, 1, 8'hed, 8'hee, 8'hef));
    compare_q("early_end");
    check_eq("early_fcnt", 32'(frame_count_o), 32'd3);
    check_eq("early_sticky", 32'(line_error_o), 32'd1);

    // Missing end: counter supplies TLAST; frame start realigned
    send(8'h71, 8'h72, 8'h73, 1'b0);
    send(8'h74, 8'h75, 8'h76, 1'b0);
    send(8'h77, 8'h78, 8'h79, 1'b0);
    idle(3);
    exp_q.push_back(px(1, 0, 8'h71, 8'h72, 8'h73));
    exp_q.push_back(px(0, 0, 8'h74, 8'h75, 8'h76));
    exp_q.push_back(px(0, 1, 8'h77, 8'h78, 8'h79));
    compare_q("missing_end");
    check_eq("missing_lerr", 32'(line_error_o), 32'd1);
    check_eq("missing_fcnt", 32'(frame_count_o), 32'd3);

    // Mid-frame reset with two buffered pixels
    master_ready_i = 1'b0;
    send(8'h91, 8'h92, 8'h93, 1'b0);
    send(8'h94, 8'h95, 8'h96, 1'b0);
    check_eq("pre_rst_valid", 32'(master_valid_o), 32'd1);
    check_eq("pre_rst_ready", 32'(slave_ready_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(master_valid_o), 32'd0);
    check_eq("mid_rst_fcnt", 32'(frame_count_o), 32'd0);
    check_eq("mid_rst_lerr", 32'(line_error_o), 32'd0);
    check_eq("mid_rst_ready", 32'(slave_ready_o), 32'd0);
    idle(2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 32'(slave_ready_o), 32'd1);
    master_ready_i = 1'b1;
    q.delete();
    send(8'h5a, 8'h5b, 8'h5c, 1'b0);
    idle(3);
    exp_q.push_back(px(1, 0, 8'h5a, 8'h5b, 8'h5c));
    compare_q("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_to_axis.md
PIXEL_STREAM_TO_AXIS -- requirements
Module: pixel_stream_to_axis

Interface
REQ-001 The block SHALL have parameter Height, default 1080, meaning output frame height in lines (>=1).
REQ-002 The block SHALL have parameter Width, default 1920, meaning output frame width in pixels (>=2).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: port clock_i input 1 system clock, rising edge; port reset_i input 1 reset.
REQ-004 Port slave_valid_i, input, 1 bit: upstream pixel valid (superresolution master side).
REQ-005 Port slave_ready_o, output, 1 bit: block can accept a pixel.
REQ-006 Ports slave_red_i, slave_green_i and slave_blue_i, input, 8 bits each: pixel components.
REQ-007 Port slave_last_i, input, 1 bit: upstream end-of-line marker.
REQ-008 Port master_valid_o, output, 1 bit: AXI4-Stream video TVALID.
REQ-009 Port master_ready_i, input, 1 bit: TREADY.
REQ-010 Port master_data_o, output, 24 bits: TDATA.
REQ-011 Port master_user_o, output, 1 bit: TUSER, start of frame.
REQ-012 Port master_last_o, output, 1 bit: TLAST, end of line.
REQ-013 Port line_error_o, output, 1 bit: sticky line-length mismatch flag.
REQ-014 Port frame_count_o, output, 16 bits: completed input frames.

Function
REQ-015 A transfer SHALL occur on a rising clock_i edge with valid and ready both high, per port pair.
REQ-016 Buffering SHALL be a 2-entry skid FIFO.
- slave_ready_o is driven from a register.
- slave_ready_o is high iff occupancy < 2 at the start of the cycle.
REQ-017 Latency SHALL be exactly 1 cycle: a pixel accepted into an empty buffer appears on master_valid_o the next cycle, with master_ready_i high.
REQ-018 Simultaneous input and output transfers SHALL leave occupancy unchanged; order is strictly FIFO.
REQ-019 Full throughput SHALL be sustained: one pixel per cycle while slave_valid_i and master_ready_i stay high.
REQ-020 master_data_o SHALL be {red, blue, green}: [23:16]=red, [15:8]=blue, [7:0]=green.
REQ-021 Column counter x (0..Width-1) and row counter y (0..Height-1) SHALL advance on each input transfer; they are not advanced by output transfers.
REQ-022 master_user_o SHALL be high for the pixel accepted with x==0 and y==0, and low otherwise.
REQ-023 master_last_o SHALL be high for a pixel accepted with x==Width-1 or slave_last_i==1.
REQ-024 After a pixel with master_last_o set, the counters SHALL update as follows: x <- 0; y <- y+1, or y <- 0 if y==Height-1.
REQ-025 Otherwise x SHALL increment by 1.
REQ-026 line_error_o SHALL set on an input transfer where slave_last_i differs from (x==Width-1).
- It holds until reset.
- The pixel is still forwarded, and the counters realign per REQ-024.
REQ-027 frame_count_o SHALL increment, modulo 2^16, on an input transfer with y==Height-1 and master_last_o set.
REQ-028 While master_valid_o is high and master_ready_i is low, master_data_o, master_user_o and master_last_o SHALL stay stable.
REQ-029 master_valid_o SHALL NOT deassert without a completed transfer.
REQ-030 slave_valid_i SHALL be ignored while slave_ready_o is low: no transfer, no counter change.

Reset
REQ-031 While reset_i is high, outputs SHALL be: master_valid_o=0, master_data_o=0, master_user_o=0, master_last_o=0, slave_ready_o=0.
REQ-032 While reset_i is high, state SHALL be: line_error_o=0, frame_count_o=0, x=0, y=0, FIFO empty.
REQ-033 Reset assertion SHALL take effect asynchronously, discarding buffered pixels mid-frame.
REQ-034 After reset deasserts, slave_ready_o SHALL go high on the first clock_i edge; the next accepted pixel carries master_user_o=1.

Verification (Height=2, Width=3)
REQ-035 Streaming test: 6 pixels valid every cycle, master_ready_i=1, slave_last_i on pixels 3 and 6.
- master_user_o on pixel 1 only; master_last_o on pixels 3 and 6.
- frame_count_o=1; line_error_o=0; 1-cycle latency.
REQ-036 Component-order test: pixel R=0x11, G=0x22, B=0x33 -> master_data_o=0x113322.
REQ-037 Backpressure test: master_ready_i=0 with 3 pixels offered.
- Only 2 are accepted; slave_ready_o goes low; output holds pixel 1 stable.
- After master_ready_i rises, all 3 are delivered in order, no loss or duplication.
REQ-038 Early-end test: slave_last_i on pixel 2 of line 1.
- master_last_o on pixel 2; line_error_o=1 and sticky.
- The next pixel is x=0, y=1; frame_user realigns at the next frame start.
REQ-039 Missing-end test: slave_last_i absent on pixel 3.
- master_last_o=1 on pixel 3 (counter-generated); line_error_o=1.
REQ-040 Mid-frame reset test: assert reset_i mid-frame with 2 buffered pixels.
- master_valid_o drops immediately; frame_count_o=0.
- The first post-reset pixel has master_user_o=1.
